// File: rtl/sprite_rom_pkg.sv
// Shared constants and shape-test helpers for the sprite pixel ROMs.
package sprite_rom_pkg;

  localparam int KIND_CHAR  = 0;
  localparam int KIND_COLL  = 1;
  localparam int KIND_SHARK = 2;

  localparam logic [2:0] S_TYPE_COIN  = 3'd0;
  localparam logic [2:0] S_TYPE_SHARK = 3'd1;
  localparam logic [2:0] S_TYPE_GEM   = 3'd2;

  // Every opaque colour is non-zero; zero is reserved for "no data".
  localparam logic [11:0] TRANSPARENT = 12'h000;
  localparam logic [11:0] C_CHAR_IDLE = 12'hF80;
  localparam logic [11:0] C_CHAR_RISE = 12'h0F0;
  localparam logic [11:0] C_CHAR_FALL = 12'hF00;
  localparam logic [11:0] C_COIN      = 12'hFD0;
  localparam logic [11:0] C_SHINE     = 12'hFF8;
  localparam logic [11:0] C_GEM       = 12'h0FF;
  localparam logic [11:0] C_SHARK     = 12'h888;
  localparam logic [11:0] C_EYE       = 12'h111;

  function automatic logic in_range(input logic [10:0] v,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Manhattan-distance diamond centred on (cx, cy) with radius r.
  function automatic logic in_diamond(input logic [10:0] x,
                                      input logic [10:0] y,
                                      input logic [10:0] cx,
                                      input logic [10:0] cy,
                                      input logic [10:0] r);
    logic [10:0] dx;
    logic [10:0] dy;
    logic [11:0] sum;
    dx  = (x >= cx) ? (x - cx) : (cx - x);
    dy  = (y >= cy) ? (y - cy) : (cy - y);
    sum = {1'b0, dx} + {1'b0, dy};
    return sum <= {1'b0, r};
  endfunction

endpackage

// File: rtl/sprite_roms_if.sv
// Lookup bus between a sprite wrapper (master) and its pixel ROM (slave).
interface sprite_roms_if #(parameter int LOG_FRAMES = 3);

  logic [10:0]           x;
  logic [10:0]           y;
  logic [2:0]            s_type;
  logic [LOG_FRAMES-1:0] frame;
  logic [11:0]           pixel;

  modport master (output x, output y, output s_type, output frame, input pixel);
  modport slave  (input x, input y, input s_type, input frame, output pixel);

endinterface

// File: rtl/collectable_rom.sv
// Collectable (coin/gem) sprite ROM wrapper for existing call sites.
module collectable_rom #(
  parameter int WIDTH      = 15,
  parameter int HEIGHT     = 16,
  parameter int LOG_FRAMES = 3
) (
  input logic          vclock,
  input logic          reset,
  sprite_roms_if.slave bus
);

  sprite_roms #(
    .KIND(1), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LOG_FRAMES(LOG_FRAMES)
  ) u_rom (
    .vclock(vclock),
    .reset (reset),
    .bus   (bus)
  );

endmodule

// File: rtl/shark_rom.sv
// Shark sprite ROM wrapper for existing call sites.
module shark_rom #(
  parameter int WIDTH      = 40,
  parameter int HEIGHT     = 20,
  parameter int LOG_FRAMES = 3
) (
  input logic          vclock,
  input logic          reset,
  sprite_roms_if.slave bus
);

  sprite_roms #(
    .KIND(2), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LOG_FRAMES(LOG_FRAMES)
  ) u_rom (
    .vclock(vclock),
    .reset (reset),
    .bus   (bus)
  );

endmodule

// File: rtl/sprite_rom.sv
// Character sprite ROM wrapper for existing call sites.
module sprite_rom #(
  parameter int WIDTH      = 20,
  parameter int HEIGHT     = 20,
  parameter int LOG_FRAMES = 3
) (
  input logic          vclock,
  input logic          reset,
  sprite_roms_if.slave bus
);

  sprite_roms #(
    .KIND(0), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LOG_FRAMES(LOG_FRAMES)
  ) u_rom (
    .vclock(vclock),
    .reset (reset),
    .bus   (bus)
  );

endmodule

// File: rtl/sprite_roms.sv
// Combinational sprite shape logic behind one output register; KIND selects the sprite.
// Define SPRITE_ROM_ANIM_EN to honour the frame input; otherwise frame is treated as 0.
import sprite_rom_pkg::*;

module sprite_roms #(
  parameter int KIND       = 0,
  parameter int WIDTH      = 20,
  parameter int HEIGHT     = 20,
  parameter int LOG_FRAMES = 3
) (
  input logic          vclock,
  input logic          reset,
  sprite_roms_if.slave bus
);

  logic [11:0]           pix_d;
  logic [LOG_FRAMES-1:0] frame_eff;
  logic [31:0]           frame_num;
  logic                  in_box;
  logic                  unused_bits;

`ifdef SPRITE_ROM_ANIM_EN
  assign frame_eff = bus.frame;
`else
  assign frame_eff = '0;
`endif

  assign frame_num   = 32'(frame_eff);
  assign unused_bits = ^{bus.s_type, bus.frame, frame_num, frame_eff};
  // Unsigned compare: wrapped negative offsets land far outside the box.
  assign in_box = (bus.x < 11'(WIDTH)) && (bus.y < 11'(HEIGHT));

  if (KIND == KIND_CHAR) begin : g_char
    always_comb begin
      pix_d = TRANSPARENT;
      if (in_box) begin
        if (in_range(bus.x, 11'd12, 11'd13) && in_range(bus.y, 11'd5, 11'd6)) begin
          pix_d = C_EYE;
        end else if (in_range(bus.x, 11'd2, 11'(WIDTH - 3)) &&
                     in_range(bus.y, 11'd2, 11'(HEIGHT - 3))) begin
          if (frame_num == 1)      pix_d = C_CHAR_RISE;
          else if (frame_num == 2) pix_d = C_CHAR_FALL;
          else                     pix_d = C_CHAR_IDLE;
        end
      end
    end
  end else if (KIND == KIND_COLL) begin : g_coll
    always_comb begin
      pix_d = TRANSPARENT;
      if (in_box && in_diamond(bus.x, bus.y, 11'd7, 11'd7, 11'd7)) begin
        if (bus.s_type == S_TYPE_COIN)     pix_d = (frame_num >= 4) ? C_SHINE : C_COIN;
        else if (bus.s_type == S_TYPE_GEM) pix_d = C_GEM;
      end
    end
  end else if (KIND == KIND_SHARK) begin : g_shark
    always_comb begin
      pix_d = TRANSPARENT;
      if (in_box && (bus.s_type == S_TYPE_SHARK)) begin
        if ((bus.x == 11'd32) && (bus.y == 11'd10)) begin
          pix_d = C_EYE;
        end else if ((in_range(bus.y, 11'd8, 11'd15) && in_range(bus.x, 11'd4, 11'd35)) ||
                     ((bus.y <= 11'd7) && in_range(bus.x, 11'd16, 11'd16 + bus.y)) ||
                     ((bus.x <= 11'd3) && (frame_eff[0] ? in_range(bus.y, 11'd4, 11'd15)
                                                        : in_range(bus.y, 11'd6, 11'd17)))) begin
          pix_d = C_SHARK;
        end
      end
    end
  end else begin : g_none
    assign pix_d = TRANSPARENT;
  end

  always_ff @(posedge vclock) begin
    if (reset) bus.pixel <= TRANSPARENT;
    else       bus.pixel <= pix_d;
  end

endmodule

// File: tb/tb_sprite_roms.sv
// Scoreboard bench for sprite_roms: directed plan points, random lookups and a latency sweep.
module tb_sprite_roms;

`ifdef SPRITE_ROM_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  localparam int N = 5;

  logic vclock = 1'b0;
  logic reset  = 1'b1;
  always #5 vclock = ~vclock;

  sprite_roms_if #(.LOG_FRAMES(3)) if_c  ();
  sprite_roms_if #(.LOG_FRAMES(3)) if_k1 ();
  sprite_roms_if #(.LOG_FRAMES(3)) if_k2 ();
  sprite_roms_if #(.LOG_FRAMES(3)) if_w  ();
  sprite_roms_if #(.LOG_FRAMES(3)) if_b  ();

  sprite_roms #(.KIND(0), .WIDTH(20), .HEIGHT(20), .LOG_FRAMES(3)) u_char (
    .vclock(vclock), .reset(reset), .bus(if_c));
  collectable_rom u_coll  (.vclock(vclock), .reset(reset), .bus(if_k1));
  shark_rom       u_shark (.vclock(vclock), .reset(reset), .bus(if_k2));
  sprite_rom      u_charw (.vclock(vclock), .reset(reset), .bus(if_w));
  sprite_roms #(.KIND(3), .WIDTH(20), .HEIGHT(20), .LOG_FRAMES(3)) u_bad (
    .vclock(vclock), .reset(reset), .bus(if_b));

  typedef struct {
    int               due;
    logic [N-1:0][11:0] exp;
  } sb_t;

  sb_t q[$];
  int  cyc    = 0;
  int  total  = 0;
  int  passed = 0;

  string names [N] = '{"char", "coll", "shark", "char_wrap", "kind3"};
  int    kinds [N] = '{0, 1, 2, 0, 3};
  int    widths[N] = '{20, 15, 40, 20, 20};
  int    heights[N] = '{20, 16, 20, 20, 20};

  always @(posedge vclock) cyc <= cyc + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference picture for one sprite, straight from the shape description.
  function automatic int ref_pixel(input int kind, input int w, input int h,
                                   input int x, input int y, input int st, input int fr);
    int f;
    f = ANIM ? fr : 0;
    if (x >= w || y >= h) return 0;
    case (kind)
      0: begin
        if (x >= 12 && x <= 13 && y >= 5 && y <= 6) return 'h111;
        if (x < 2 || x > w - 3 || y < 2 || y > h - 3) return 0;
        if (f == 1) return 'h0F0;
        if (f == 2) return 'hF00;
        return 'hF80;
      end
      1: begin
        if (iabs(x - 7) + iabs(y - 7) > 7) return 0;
        if (st == 0) return (f >= 4) ? 'hFF8 : 'hFD0;
        if (st == 2) return 'h0FF;
        return 0;
      end
      2: begin
        if (st != 1) return 0;
        if (x == 32 && y == 10) return 'h111;
        if (y >= 8 && y <= 15 && x >= 4 && x <= 35) return 'h888;
        if (y <= 7 && x >= 16 && x <= 16 + y) return 'h888;
        if (x <= 3) begin
          if (f % 2 == 0 && y >= 6 && y <= 17) return 'h888;
          if (f % 2 == 1 && y >= 4 && y <= 15) return 'h888;
        end
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  task automatic drive(input int x, input int y, input int st, input int fr, input bit rst);
    sb_t e;
    @(posedge vclock);
    #1;
    reset = rst;
    if_c.x  = 11'(x); if_c.y  = 11'(y); if_c.s_type  = 3'(st); if_c.frame  = 3'(fr);
    if_k1.x = 11'(x); if_k1.y = 11'(y); if_k1.s_type = 3'(st); if_k1.frame = 3'(fr);
    if_k2.x = 11'(x); if_k2.y = 11'(y); if_k2.s_type = 3'(st); if_k2.frame = 3'(fr);
    if_w.x  = 11'(x); if_w.y  = 11'(y); if_w.s_type  = 3'(st); if_w.frame  = 3'(fr);
    if_b.x  = 11'(x); if_b.y  = 11'(y); if_b.s_type  = 3'(st); if_b.frame  = 3'(fr);
    e.due = cyc + 1;
    for (int i = 0; i < N; i++)
      e.exp[i] = rst ? 12'h000 : 12'(ref_pixel(kinds[i], widths[i], heights[i], x, y, st, fr));
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Monitor: a lookup result is due on the negedge after the edge that registered it.
  initial begin
    sb_t e;
    logic [N-1:0][11:0] act;
    forever begin
      @(negedge vclock);
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        check("stale_entry", 12'hFFF, 12'h000);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        act = {if_b.pixel, if_w.pixel, if_k2.pixel, if_k1.pixel, if_c.pixel};
        for (int i = 0; i < N; i++) check(names[i], act[i], e.exp[i]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    int x, y, st, fr;
    bit rst;
    if_c.x  = 11'd5; if_c.y  = 11'd5; if_c.s_type  = 3'd0; if_c.frame  = 3'd0;
    if_k1.x = 11'd5; if_k1.y = 11'd5; if_k1.s_type = 3'd0; if_k1.frame = 3'd0;
    if_k2.x = 11'd5; if_k2.y = 11'd5; if_k2.s_type = 3'd0; if_k2.frame = 3'd0;
    if_w.x  = 11'd5; if_w.y  = 11'd5; if_w.s_type  = 3'd0; if_w.frame  = 3'd0;
    if_b.x  = 11'd5; if_b.y  = 11'd5; if_b.s_type  = 3'd0; if_b.frame  = 3'd0;

    // Reset holds pixel at zero, then the first edge after release looks up.
    drive(5, 5, 0, 0, 1);
    drive(5, 5, 0, 0, 1);
    drive(7, 7, 0, 0, 1);
    drive(20, 10, 1, 0, 1);
    drive(5, 5, 0, 0, 0);

    // Character frames and bounds.
    drive(5, 5, 0, 1, 0);
    drive(5, 5, 0, 2, 0);
    drive(12, 6, 0, 0, 0);
    drive(1, 5, 0, 0, 0);
    drive(2047, 5, 0, 0, 0);
    drive(17, 17, 0, 0, 0);
    drive(18, 5, 0, 0, 0);

    // Coin and gem.
    drive(7, 7, 0, 0, 0);
    drive(7, 7, 0, 5, 0);
    drive(0, 0, 0, 0, 0);
    drive(7, 7, 1, 0, 0);
    drive(7, 0, 2, 0, 0);
    drive(14, 7, 2, 0, 0);
    drive(15, 7, 0, 0, 0);

    // Shark.
    drive(20, 10, 1, 0, 0);
    drive(16, 0, 1, 0, 0);
    drive(17, 0, 1, 0, 0);
    drive(32, 10, 1, 0, 0);
    drive(20, 10, 0, 0, 0);
    drive(40, 10, 1, 0, 0);
    drive(1, 5, 1, 0, 0);
    drive(1, 5, 1, 1, 0);
    drive(2, 17, 1, 0, 0);
    drive(2, 17, 1, 1, 0);

    // Random lookups with occasional resets and huge wrapped offsets.
    for (int n = 0; n < 300; n++) begin
      x   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 44));
      y   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 22));
      st  = $urandom_range(0, 7);
      fr  = $urandom_range(0, 7);
      rst = ($urandom_range(0, 39) == 0);
      drive(x, y, st, fr, rst);
    end

    // Back-to-back sweep across the character row.
    for (int i = 0; i < 20; i++) drive(i, 2, 0, 0, 0);

    repeat (3) @(posedge vclock);
    @(negedge vclock);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d results never presented, expected 0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sprite_roms.md
Name: sprite_roms

Overview:
Parameterised pixel ROM for every game sprite: the surfer character, the collectables and the shark.
- The sprite wrappers present sprite-relative coordinates plus sprite type and animation frame.
- The block returns one 12-bit RGB pixel one clock later.
- Pixel value 12'h000 means transparent; the display compositor treats zero as "no data".
- One instance per sprite wrapper, selected by KIND.

Parameters:
- KIND, default 0: 0 = character, 1 = collectable, 2 = shark. Other values: output always 0.
- WIDTH, default 20: sprite width in pixels. Use 20 for character, 15 for collectable, 40 for shark.
- HEIGHT, default 20: sprite height in pixels. Use 20 for character, 16 for collectable, 20 for shark.
- LOG_FRAMES, default 3: width of the frame input.

Ports:
- vclock  in  1  65 MHz pixel clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- x  in  11  sprite-relative column (hcount − sprite x; may be wrapped or huge).
- y  in  11  sprite-relative row.
- s_type  in  3  sprite identity; 2-bit sources are zero-extended. Ignored when KIND=0.
- frame  in  LOG_FRAMES  animation frame.
- pixel  out  12  RGB 4:4:4 pixel; 0 = transparent.

Behaviour:
- Output register: pixel is registered, 1-cycle latency from x/y/s_type/frame. No handshake; a new lookup every cycle.
- Reset: reset=1 at a clock edge → pixel=0 on that edge; the lookup resumes on the first edge after deassertion.
- Out of box: x ≥ WIDTH or y ≥ HEIGHT → 0. Comparisons are unsigned 11-bit, so wrapped negatives are rejected.
- KIND=0, character:
  - Body: opaque for 2≤x≤WIDTH−3 and 2≤y≤HEIGHT−3; everything else in the box is 0.
  - Body colour by frame: 1 → 12'h0F0, 2 → 12'hF00, all other frames → 12'hF80.
  - Eye: x∈{12,13}, y∈{5,6} → 12'h111, overriding the body colour.
- KIND=1, collectable:
  - s_type 0, coin: opaque where |x−7|+|y−7| ≤ 7. Colour 12'hFD0; 12'hFF8 when frame ≥ 4 (shine).
  - s_type 2, gem: same diamond, colour 12'h0FF.
  - s_type 1, 3 and 4..7: 0 everywhere.
- KIND=2, shark: only s_type 1 draws; every other type is 0 everywhere.
  - Body: y 8..15, x 4..35 → 12'h888.
  - Fin: y 0..7 with 16 ≤ x ≤ 16+y → 12'h888.
  - Tail: x 0..3, y 6..17 when frame[0]=0, y 4..15 when frame[0]=1 → 12'h888.
  - Eye: x=32, y=10 → 12'h111.
  - All other pixels → 0.
- Non-zero rule: every opaque colour is non-zero, so the compositor never mistakes a drawn pixel for transparency.
- Implementation: purely combinational shape logic feeding the single output register; no memories or initialisation files.

Optional Feature:
- Macro SPRITE_ROM_ANIM_EN.
- Defined: frame is honoured as described above.
- Undefined: frame is forced to 0 internally. The character is always 12'hF80, the coin never shines, the shark tail is fixed at y 6..17. The port remains present and is unused.

Decomposition:
- Package sprite_rom_pkg holds:
  - KIND_CHAR/KIND_COLL/KIND_SHARK constants.
  - S_TYPE_COIN=0, S_TYPE_SHARK=1, S_TYPE_GEM=2.
  - Colour constants: TRANSPARENT, C_CHAR_IDLE/RISE/FALL, C_COIN, C_SHINE, C_GEM, C_SHARK, C_EYE.
  - Shape-test functions: diamond test and in-range test.
- No sub-module: one module with a generate-on-KIND case.
- Thin wrappers named collectable_rom, shark_rom and sprite_rom instantiate sprite_roms with KIND 1, 2 and 0 for existing call sites.

Test Plan:
- Reset: drive x=5, y=5, frame=0, KIND=0, reset=1 → pixel=0 on every edge. After deassert, the next edge → 12'hF80.
- Character frames and bounds, KIND=0, x=5, y=5:
  - frame 1 → 12'h0F0; frame 2 → 12'hF00 one cycle later.
  - x=12, y=6 → 12'h111.
  - x=1 → 0.
  - x=11'h7FF (wrapped negative) → 0.
- Coin, KIND=1:
  - s_type 0, x=7, y=7, frame 0 → 12'hFD0; frame 5 → 12'hFF8.
  - x=0, y=0 → 0.
  - s_type 1 at x=7, y=7 → 0.
- Shark, KIND=2, s_type 1:
  - x=20, y=10 → 12'h888.
  - x=16, y=0 → 12'h888; x=17, y=0 → 0.
  - x=32, y=10 → 12'h111.
  - s_type 0 anywhere → 0.
  - x=40 → 0.
- Shark tail animation:
  - x=1, y=5: frame 0 → 0; frame 1 → 12'h888.
  - With SPRITE_ROM_ANIM_EN undefined, frame 1 → 0.
- Latency: sweep x 0..19 on consecutive cycles at y=2 with KIND=0. The output sequence equals the expected shape delayed exactly one clock, with no bubbles.
